// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular transmit buffer that feeds the UART TX frame controller one word per frame.
// Optional status ports (COUNT, OVERFLOW, OVF_CLR) are built when UART_TX_FIFO_STATUS_EN is defined.
module uart_tx_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WR_EN,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   output logic                  FULL,
   output logic                  EMPTY,
   input  logic                  TX_BUSY,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID
`ifdef UART_TX_FIFO_STATUS_EN
   ,
   output logic [DEPTH_LOG2:0]   COUNT,
   output logic                  OVERFLOW,
   input  logic                  OVF_CLR
`endif
);

   localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;
   localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   state_t                state;
   state_t                state_nxt;
   logic                  dv_nxt;
   logic                  pop_c;
   logic                  wr_acc_c;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign EMPTY    = (wr_ptr == rd_ptr);
   assign FULL     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign wr_acc_c = WR_EN && !FULL;

   // Issue sequencing: one pulse per word, then wait for the frame to start and finish.
   always_comb begin
      state_nxt = state;
      dv_nxt    = 1'b0;
      pop_c     = 1'b0;
      case (state)
         IDLE: begin
            if (!EMPTY && !TX_BUSY) begin
               pop_c     = 1'b1;
               dv_nxt    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (TX_BUSY)  state_nxt = WAIT_DONE;
         WAIT_DONE: if (!TX_BUSY) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         DATA_VALID <= 1'b0;
         P_DATA     <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         state      <= state_nxt;
         DATA_VALID <= dv_nxt;
         if (pop_c) begin
            P_DATA <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (wr_acc_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
      end
   end

   // Storage carries no reset; contents are only meaningful between the pointers.
   always_ff @(posedge CLK) begin
      if (wr_acc_c) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= WR_DATA;
      end
   end

`ifdef UART_TX_FIFO_STATUS_EN
   assign COUNT = wr_ptr - rd_ptr;

   // Sticky drop indicator; a new drop wins over a clear on the same edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         OVERFLOW <= 1'b0;
      end else if (WR_EN && FULL) begin
         OVERFLOW <= 1'b1;
      end else if (OVF_CLR) begin
         OVERFLOW <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a queue-based reference
// model and a behavioural transmitter that goes busy one cycle after each DATA_VALID pulse.
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH = 16;

   logic       CLK;
   logic       RST;
   logic       WR_EN;
   logic [7:0] WR_DATA;
   logic       FULL;
   logic       EMPTY;
   logic       TX_BUSY;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
`ifdef UART_TX_FIFO_STATUS_EN
   logic [4:0] COUNT;
   logic       OVERFLOW;
   logic       OVF_CLR;
`endif

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] ref_q[$];
   logic [7:0] got_q[$];
   logic [7:0] sent_q[$];
   logic       tx_force;
   logic       tx_model_busy;
   int         tx_delay;
   int         tx_left;
   int         tx_len;
   bit         tx_rand;
   bit         prev_dv;
   bit         frame_open;
   bit         seen_hi;

   assign TX_BUSY = tx_force | tx_model_busy;

   uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .WR_EN      (WR_EN),
      .WR_DATA    (WR_DATA),
      .FULL       (FULL),
      .EMPTY      (EMPTY),
      .TX_BUSY    (TX_BUSY),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID)
`ifdef UART_TX_FIFO_STATUS_EN
      ,
      .COUNT      (COUNT),
      .OVERFLOW   (OVERFLOW),
      .OVF_CLR    (OVF_CLR)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor plus transmitter model; all sampling on the falling edge.
   always @(negedge CLK) begin
      if (!RST) begin
         prev_dv       = 1'b0;
         frame_open    = 1'b0;
         seen_hi       = 1'b0;
         tx_model_busy = 1'b0;
         tx_delay      = 0;
         tx_left       = 0;
      end else begin
         if (DATA_VALID) begin
            chk("dv_width", 32'(prev_dv), 32'(0));
            chk("dv_spacing", 32'(frame_open), 32'(0));
            chk("dv_has_entry", 32'(ref_q.size() != 0), 32'(1));
            if (ref_q.size() != 0) chk("p_data_order", 32'(P_DATA), 32'(ref_q.pop_front()));
            got_q.push_back(P_DATA);
            frame_open = 1'b1;
            seen_hi    = 1'b0;
         end else if (frame_open) begin
            if (TX_BUSY) seen_hi = 1'b1;
            else if (seen_hi) frame_open = 1'b0;
         end
         prev_dv = DATA_VALID;
         if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) tx_model_busy = 1'b0;
         end else if (tx_delay > 0) begin
            tx_delay--;
            if (tx_delay == 0) begin
               tx_model_busy = 1'b1;
               tx_left = tx_rand ? int'($urandom_range(1, 6)) : tx_len;
            end
         end
         if (DATA_VALID) tx_delay = 1;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
      #1;
   endtask

   task automatic wr(input logic [7:0] d);
      WR_EN   = 1'b1;
      WR_DATA = d;
      step();
      WR_EN   = 1'b0;
      if (ref_q.size() < DEPTH) ref_q.push_back(d);
   endtask

   task automatic drain();
      int i = 0;
      while (i < 3000 && !(ref_q.size() == 0 && !TX_BUSY && tx_delay == 0 && !DATA_VALID)) begin
         step();
         i++;
      end
      repeat (3) step();
      chk("drain_model_empty", 32'(ref_q.size()), 32'(0));
      chk("drain_EMPTY", 32'(EMPTY), 32'(1));
   endtask

   initial begin
      logic [7:0] e3[3];
      logic [7:0] d;
      int         guard;
      e3 = '{8'h11, 8'h22, 8'h33};
      RST = 1'b0; WR_EN = 1'b0; WR_DATA = 8'h00;
      tx_force = 1'b0; tx_len = 10; tx_rand = 1'b0;
`ifdef UART_TX_FIFO_STATUS_EN
      OVF_CLR = 1'b0;
`endif
      #1;
      chk("rst_EMPTY", 32'(EMPTY), 32'(1));
      chk("rst_FULL", 32'(FULL), 32'(0));
      chk("rst_DATA_VALID", 32'(DATA_VALID), 32'(0));
      chk("rst_P_DATA", 32'(P_DATA), 32'(0));
      repeat (3) step();
      RST = 1'b1;
      step();

      // Single write: pulse lands between edges N+1 and N+2.
      wr(8'hA5);
      sample(); chk("t1_dv_n0", 32'(DATA_VALID), 32'(0));
      sample(); chk("t1_dv_n1", 32'(DATA_VALID), 32'(1));
      chk("t1_pdata_n1", 32'(P_DATA), 32'hA5);
      sample(); chk("t1_dv_n2", 32'(DATA_VALID), 32'(0));
      chk("t1_pdata_n2", 32'(P_DATA), 32'hA5);
      chk("t1_empty", 32'(EMPTY), 32'(1));
      drain();
      chk("t1_pdata_hold", 32'(P_DATA), 32'hA5);

      // Three back-to-back words, 10-cycle frames.
      got_q.delete();
      wr(8'h11); wr(8'h22); wr(8'h33);
      drain();
      chk("t2_count", 32'(got_q.size()), 32'(3));
      for (int i = 0; i < 3; i++)
         if (i < got_q.size()) chk("t2_word", 32'(got_q[i]), 32'(e3[i]));

      // Fill while transmitter busy; 17th write dropped.
      got_q.delete();
      tx_force = 1'b1;
      for (int i = 0; i < 16; i++) wr(8'(i));
      sample();
      chk("t3_full", 32'(FULL), 32'(1));
      chk("t3_not_empty", 32'(EMPTY), 32'(0));
      wr(8'h10);
      sample();
      chk("t3_full_after_drop", 32'(FULL), 32'(1));
`ifdef UART_TX_FIFO_STATUS_EN
      chk("t3_count", 32'(COUNT), 32'(16));
      chk("t3_overflow", 32'(OVERFLOW), 32'(1));
      OVF_CLR = 1'b1; step(); OVF_CLR = 1'b0;
      sample();
      chk("t3_overflow_clr", 32'(OVERFLOW), 32'(0));
`endif
      tx_force = 1'b0;
      drain();
      chk("t3_issued", 32'(got_q.size()), 32'(16));
      for (int i = 0; i < 16; i++)
         if (i < got_q.size()) chk("t3_word", 32'(got_q[i]), 32'(i));

      // Write on the same edge as the IDLE pop with 4 entries held.
      got_q.delete();
      tx_force = 1'b1;
      for (int i = 0; i < 4; i++) wr(8'h40 + 8'(i));
      tx_force = 1'b0;
      wr(8'h44);
      sample();
      chk("t4_dv", 32'(DATA_VALID), 32'(1));
      chk("t4_empty", 32'(EMPTY), 32'(0));
      chk("t4_full", 32'(FULL), 32'(0));
`ifdef UART_TX_FIFO_STATUS_EN
      chk("t4_count", 32'(COUNT), 32'(4));
`endif
      drain();
      chk("t4_issued", 32'(got_q.size()), 32'(5));
      for (int i = 0; i < 5; i++)
         if (i < got_q.size()) chk("t4_word", 32'(got_q[i]), 32'(8'h40 + 8'(i)));

      // Reset during WAIT_DONE with 5 words queued.
      tx_len = 30;
      for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i));
      repeat (5) step();
      chk("t5_busy_mid", 32'(TX_BUSY), 32'(1));
      chk("t5_queued", 32'(EMPTY), 32'(0));
      RST = 1'b0;
      tx_force = 1'b1;
      ref_q.delete();
      #1;
      chk("t5_rst_EMPTY", 32'(EMPTY), 32'(1));
      chk("t5_rst_dv", 32'(DATA_VALID), 32'(0));
      chk("t5_rst_pdata", 32'(P_DATA), 32'(0));
      chk("t5_rst_FULL", 32'(FULL), 32'(0));
      repeat (2) step();
      got_q.delete();
      RST = 1'b1;
      tx_len = 10;
      repeat (5) step();
      chk("t5_no_issue_busy", 32'(got_q.size()), 32'(0));
      tx_force = 1'b0;
      repeat (5) step();
      chk("t5_no_issue_empty", 32'(got_q.size()), 32'(0));
      tx_force = 1'b1;
      wr(8'h77);
      repeat (5) step();
      chk("t5_hold_while_busy", 32'(got_q.size()), 32'(0));
      chk("t5_pending", 32'(EMPTY), 32'(0));
      tx_force = 1'b0;
      drain();
      chk("t5_issued", 32'(got_q.size()), 32'(1));
      if (got_q.size() > 0) chk("t5_word", 32'(got_q[0]), 32'h77);

      // Random traffic through pointer wrap with random frame lengths.
      got_q.delete();
      tx_rand = 1'b1;
      guard = 0;
      while (sent_q.size() < 40 && guard < 5000) begin
         guard++;
         if ($urandom_range(0, 3) != 0 && ref_q.size() < DEPTH) begin
            d = 8'($urandom);
            wr(d);
            sent_q.push_back(d);
            sample();
            chk("t6_full", 32'(FULL), 32'(ref_q.size() == DEPTH));
            chk("t6_empty", 32'(EMPTY), 32'(ref_q.size() == 0));
         end else begin
            step();
         end
      end
      drain();
      chk("t6_sent", 32'(sent_q.size()), 32'(40));
      chk("t6_issued", 32'(got_q.size()), 32'(sent_q.size()));
      for (int i = 0; i < 40; i++)
         if (i < got_q.size() && i < sent_q.size())
            chk("t6_word", 32'(got_q[i]), 32'(sent_q[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
